// File: rtl/twofish_pkg.sv
// Shared Twofish constants and types: byte/stage counts, the h-function
// q-select table and the sequencer state encoding.
package twofish_pkg;

  localparam int NUM_BYTES   = 4;
  localparam int NUM_QSTAGES = 3;

  localparam logic [1:0] LAST_BYTE  = 2'(NUM_BYTES - 1);
  localparam logic [1:0] LAST_STAGE = 2'(NUM_QSTAGES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // q-select table for k=2: 0 selects q0, 1 selects q1; stage 0 is innermost.
  //   byte0: q0 q0 q1 | byte1: q1 q0 q0 | byte2: q0 q1 q1 | byte3: q1 q1 q0
  function automatic logic qsel_lookup(input logic [1:0] byte_idx,
                                       input logic [1:0] stage_idx);
    logic sel;
    case ({byte_idx, stage_idx})
      4'b00_10, 4'b01_00, 4'b10_01,
      4'b10_10, 4'b11_00, 4'b11_01: sel = 1'b1;
      default:                      sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/twofish_h_sequencer_if.sv
// Bundle of the word handshake, result handshake and shared q-box port
// of the Twofish h-function sequencer.
interface twofish_h_sequencer_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_l0;
  logic [31:0] in_l1;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;

  logic        q_req;
  logic        q_gnt;
  logic        q_sel;
  logic [7:0]  q_in;
  logic [7:0]  q_out;

  // master: the sequencer; slave: the surrounding key-schedule and q-box side
  modport master (
    input  in_valid, in_x, in_l0, in_l1, out_ready, q_gnt, q_out,
    output in_ready, out_valid, out_y, q_req, q_sel, q_in
  );

  modport slave (
    output in_valid, in_x, in_l0, in_l1, out_ready, q_gnt, q_out,
    input  in_ready, out_valid, out_y, q_req, q_sel, q_in
  );

endinterface

// File: rtl/twofish_h_sequencer.sv
// Twofish k=2 h-function byte chain (pre-MDS), run one q-box op at a time
// over a shared, request/grant arbitrated q0/q1 port.
module twofish_h_sequencer
  import twofish_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  twofish_h_sequencer_if.master bus
);

  seq_state_e  state_q, state_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  stage_q, stage_d;
  logic [31:0] x_q, l0_q, l1_q;
  logic [7:0]  acc_q, acc_d;
  logic [31:0] y_q, y_d;
  logic        lat_en;

  logic [7:0]  x_byte, l0_byte, l1_byte;

  assign x_byte  = x_q [{byte_q, 3'b000} +: 8];
  assign l0_byte = l0_q[{byte_q, 3'b000} +: 8];
  assign l1_byte = l1_q[{byte_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      byte_q  <= '0;
      stage_q <= '0;
      x_q     <= '0;
      l0_q    <= '0;
      l1_q    <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      stage_q <= stage_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      if (lat_en) begin
        x_q  <= bus.in_x;
        l0_q <= bus.in_l0;
        l1_q <= bus.in_l1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    stage_d       = stage_q;
    acc_d         = acc_q;
    y_d           = y_q;
    lat_en        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.q_req     = 1'b0;
    bus.q_sel     = 1'b0;
    bus.q_in      = '0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          lat_en  = 1'b1;
          byte_d  = '0;
          stage_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        bus.q_req = 1'b1;
        bus.q_sel = qsel_lookup(byte_q, stage_q);
        case (stage_q)
          2'd0:    bus.q_in = x_byte;
          2'd1:    bus.q_in = acc_q ^ l1_byte;
          default: bus.q_in = acc_q ^ l0_byte;
        endcase

        // Operands depend only on registered state, so they hold while ungranted.
        if (bus.q_gnt) begin
          if (stage_q == LAST_STAGE) begin
            y_d[{byte_q, 3'b000} +: 8] = bus.q_out;
            stage_d = '0;
            byte_d  = byte_q + 2'd1;
            if (byte_q == LAST_BYTE) begin
              state_d = DONE;
            end
          end else begin
            acc_d   = bus.q_out;
            stage_d = stage_q + 2'd1;
          end
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.out_y = y_q;

endmodule

// File: tb/tb_twofish_h_sequencer.sv
// Directed bench for twofish_h_sequencer with a q-box stub and a word-level
// reference model checked every cycle.
module tb_twofish_h_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  twofish_h_sequencer_if bus();

  twofish_h_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        mode  = 1'b0;
  logic        stall = 1'b0;
  int          runcyc = 0;
  int          op_idx = 0;
  logic [11:0] sel_log = '0;
  logic [31:0] exp_y = '0;
  logic        exp_sel [12];
  logic [7:0]  exp_qin [12];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_qin = '0;

  int sel_tab [4][3] = '{'{0, 0, 1}, '{1, 0, 0}, '{0, 1, 1}, '{1, 1, 0}};

  // mode 0: identity; mode 1: q0 adds one, q1 flips bit 7
  function automatic logic [7:0] qbox(input logic s, input logic [7:0] v, input logic m);
    if (!m) return v;
    return s ? (v ^ 8'h80) : (v + 8'd1);
  endfunction

  assign bus.q_out = qbox(bus.q_sel, bus.q_in, mode);
  assign bus.q_gnt = stall ? runcyc[0] : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: on each accepted word, build the expected op list and result.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) begin
      automatic logic [7:0]  v = '0;
      automatic logic [31:0] y = '0;
      automatic logic        s;
      for (int b = 0; b < 4; b++) begin
        for (int st = 0; st < 3; st++) begin
          if (st == 0)      v = bus.in_x[8*b +: 8];
          else if (st == 1) v = v ^ bus.in_l1[8*b +: 8];
          else              v = v ^ bus.in_l0[8*b +: 8];
          s = (sel_tab[b][st] != 0);
          exp_sel[b*3+st] <= s;
          exp_qin[b*3+st] <= v;
          v = qbox(s, v, mode);
        end
        y[8*b +: 8] = v;
      end
      exp_y   <= y;
      op_idx  <= 0;
      runcyc  <= 0;
      sel_log <= '0;
    end else if (rst_n && bus.q_req) begin
      runcyc <= runcyc + 1;
      if (bus.q_gnt && op_idx < 12) begin
        sel_log[op_idx] <= bus.q_sel;
        op_idx <= op_idx + 1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.q_req) begin
        check("run_ctrl", {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
        if (op_idx < 12) begin
          check("q_sel", {31'd0, bus.q_sel}, {31'd0, exp_sel[op_idx]});
          check("q_in", {24'd0, bus.q_in}, {24'd0, exp_qin[op_idx]});
        end else begin
          check("op_overrun", 32'(op_idx), 32'd11);
        end
      end
      if (bus.out_valid) begin
        check("out_y", bus.out_y, exp_y);
        check("done_ctrl", {30'd0, bus.q_req, bus.in_ready}, 32'd0);
        check("op_count", 32'(op_idx), 32'd12);
      end
      if (bus.in_ready) begin
        check("idle_ctrl", {30'd0, bus.q_req, bus.out_valid}, 32'd0);
      end
      if (prev_stall) begin
        check("q_in_hold", {24'd0, bus.q_in}, {24'd0, prev_qin});
      end
      prev_stall <= bus.q_req && !bus.q_gnt;
      prev_qin   <= bus.q_in;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_word(input logic [31:0] x, input logic [31:0] l0, input logic [31:0] l1,
                         input int exp_lat, input int hold, input logic [31:0] lit_y);
    int acc_c;
    @(negedge clk);
    bus.in_x = x; bus.in_l0 = l0; bus.in_l1 = l1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ready();
    acc_c = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_x = ~x; bus.in_l0 = ~l0; bus.in_l1 = ~l1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    wait_valid();
    check("latency", 32'(cyc - acc_c), 32'(exp_lat));
    check("result_lit", bus.out_y, lit_y);
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_y", bus.out_y, lit_y);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  initial begin
    int n;
    int acc_c;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_x = '0; bus.in_l0 = '0; bus.in_l1 = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_q_req", {31'd0, bus.q_req}, 32'd0);
    check("rst_q_sel", {31'd0, bus.q_sel}, 32'd0);
    check("rst_q_in", {24'd0, bus.q_in}, 32'd0);
    check("rst_out_y", bus.out_y, 32'd0);
    rst_n = 1'b1;

    // Identity stub
    do_word(32'h11223344, 32'h0F0F0F0F, 32'hF0F0F0F0, 13, 0, 32'hEEDDCCBB);

    // Select-order stub
    mode = 1'b1;
    do_word(32'h0, 32'h0, 32'h0, 13, 0, 32'h01018282);
    check("qsel_seq", {20'd0, sel_log}, {20'd0, 12'b011110001100});
    mode = 1'b0;

    // Grant denied on every other RUN cycle
    stall = 1'b1;
    do_word(32'h11223344, 32'h0F0F0F0F, 32'hF0F0F0F0, 25, 0, 32'hEEDDCCBB);
    stall = 1'b0;

    // Back-pressure in DONE
    do_word(32'hA5A5A5A5, 32'h3C3C3C3C, 32'h00FF00FF, 13, 5, 32'h99669966);

    // Reset after the 6th q-op
    @(negedge clk);
    bus.in_x = 32'h11223344; bus.in_l0 = 32'h0F0F0F0F; bus.in_l1 = 32'hF0F0F0F0;
    bus.in_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (op_idx != 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ops_before_rst", 32'(op_idx), 32'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_q_req", {31'd0, bus.q_req}, 32'd0);
    check("midrst_out_y", bus.out_y, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_word(32'hA5A5A5A5, 32'h3C3C3C3C, 32'h00FF00FF, 13, 0, 32'h99669966);

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    bus.in_x = 32'h11223344; bus.in_l0 = 32'h0F0F0F0F; bus.in_l1 = 32'hF0F0F0F0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    wait_ready();
    acc_c = cyc;
    @(negedge clk);
    bus.in_x = 32'hA5A5A5A5; bus.in_l0 = 32'h3C3C3C3C; bus.in_l1 = 32'h00FF00FF;
    wait_valid();
    check("b2b_lat_a", 32'(cyc - acc_c), 32'd13);
    check("b2b_y_a", bus.out_y, 32'hEEDDCCBB);
    @(negedge clk);
    check("b2b_idle_after_hs", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    acc_c = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid();
    check("b2b_lat_b", 32'(cyc - acc_c), 32'd13);
    check("b2b_y_b", bus.out_y, 32'h99669966);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_final_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/twofish_h_sequencer.md
Name: twofish_h_sequencer

Overview:
- Sequences the Twofish 128-bit-key h-function (k=2) byte permutation chain over one shared external q-box port.
- Each accepted 32-bit word is split into four bytes. Each byte passes through three q-stages with key-byte XORs, processed serially.
- The 32-bit pre-MDS result is returned on a valid/ready handshake.
- Sits between key-schedule/round control and the shared q0/q1 permutation units. Request/grant lets the q-box be shared with other clients.

Parameters:
- none (k=2 is fixed; the byte count of 4 and stage count of 3 are package constants)

Ports:
- clk        in   1   system clock, rising edge
- rst_n      in   1   asynchronous, active-low reset
- in_valid   in   1   input word valid
- in_ready   out  1   sequencer can accept a word
- in_x       in   32  h input word X; byte i = in_x[8i+7:8i]
- in_l0      in   32  key word L0; byte i = l0_i
- in_l1      in   32  key word L1; byte i = l1_i
- out_valid  out  1   result valid
- out_ready  in   1   consumer accepts the result
- out_y      out  32  pre-MDS result {y3,y2,y1,y0}
- q_req      out  1   q-box operation requested this cycle
- q_gnt      in   1   q-box granted this cycle (combinational response allowed)
- q_sel      out  1   0 = q0, 1 = q1
- q_in       out  8   q-box operand
- q_out      in   8   q-box result, combinational in the same cycle as q_in

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (async, rst_n=0): state=IDLE; byte counter=0; stage counter=0; all data registers=0. Outputs: in_ready=1, out_valid=0, q_req=0, q_sel=0, q_in=0, out_y=0.
- IDLE:
  - in_ready=1.
  - in_valid=1 at an edge latches x, l0 and l1, sets byte=0 and stage=0, and moves to RUN.
  - in_valid=0 holds IDLE.
- RUN:
  - in_ready=0 and q_req=1.
  - q_in = stage0: x_byte; stage1: acc ^ l1_byte; stage2: acc ^ l0_byte. acc is the registered previous-stage result.
  - q_sel comes from a fixed per-byte table, listed innermost stage first:
    - byte0: q0, q0, q1
    - byte1: q1, q0, q0
    - byte2: q0, q1, q1
    - byte3: q1, q1, q0
  - An edge with q_gnt=1 stores q_out into acc and advances the stage.
  - After stage2, acc is written into out_y[byte], stage returns to 0 and byte increments.
  - An edge with q_gnt=0 holds all counters and acc. q_in and q_sel stay stable while ungranted.
  - Completing byte3 stage2 moves to DONE.
- Latency: with q_gnt held at 1, the acceptance edge is cycle 0, q-ops occupy cycles 1..12, and out_valid=1 from cycle 13. Each ungranted cycle adds exactly one cycle.
- DONE:
  - out_valid=1 and out_y is stable.
  - An edge with out_ready=1 returns to IDLE.
  - There is no pipelining: one word is in flight at a time.
  - in_ready=0 in DONE, so a new word is accepted no earlier than the cycle after the result handshake.
- q_req=0 in IDLE and DONE. q_in and q_sel are don't-care then but are driven to 0.
- Reset mid-RUN or mid-DONE aborts immediately. The partial result is discarded and the next word starts clean.
- in_x, in_l0 and in_l1 changing during RUN has no effect, because they are latched at acceptance.
- out_ready=1 during RUN has no effect.
- Arithmetic: XOR only, all 8-bit, no carries.

Decomposition:
- Shared package twofish_pkg:
  - constants NUM_BYTES=4 and NUM_QSTAGES=3
  - the 4x3 q-select table
  - state enum {IDLE, RUN, DONE}
- The sequencer itself is flat: FSM, counters, datapath muxing.
- One natural optional sub-module, twofish_q_arbiter, grants the shared q0/q1 units among multiple sequencers. It is not part of this block.

Test Plan:
- Identity stub (q_out=q_in, q_gnt=1); x=0x11223344, l0=0x0F0F0F0F, l1=0xF0F0F0F0 -> out_y=0xEEDDCCBB; out_valid rises exactly 13 cycles after acceptance.
- Select-order stub (q0: q_out=q_in+1 mod 256; q1: q_out=q_in^0x80); x=l0=l1=0 -> out_y=0x01018282. Observed q_sel sequence 0,0,1, 1,0,0, 0,1,1, 1,1,0.
- Grant stalls: identity stub with q_gnt low on every other RUN cycle -> same result as the first test; out_valid at cycle 25; q_in stable across each ungranted cycle.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_y held, in_ready=0. Release -> IDLE; next word accepted no earlier than the following cycle.
- Reset mid-RUN: assert rst_n=0 after the 6th q-op -> out_valid=0, in_ready=1 at once. The next word completes correctly in 13 cycles.
- Back-to-back: two words with in_valid held high and out_ready=1 -> the second accept occurs in IDLE after the first result handshake. Both results are correct; no q_req occurs in IDLE or DONE.
